fx2_rothm_pipe: RTL
===================

Name: fx2_rothm_pipe

Overview:
- Right-direction companion to the FX2 left halfword rotate (roth).
- Executes SPU rotate-and-mask halfword (rothm, logical right shift) and rotate-and-mask-algebraic halfword (rotmah, arithmetic right shift) on 8 halfword lanes.
- Two-stage registered pipeline in the FX2 pipe, with valid, stall and flush control and a target-register tag carried alongside the data.

Parameters:
- TAG_W, 7, width of the target register address carried with the op.
- LANES, 8, number of 16-bit halfword lanes (fixed at 8 for 128-bit operands).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operation present this cycle
- in_op  input  1  0 = rothm (logical), 1 = rotmah (algebraic)
- ra  input  [0:127]  source halfwords; bit 0 is the MSB of halfword 0
- rb  input  [0:127]  per-lane count halfwords
- in_tag  input  TAG_W  target register address
- stall  input  1  hold both stages
- flush  input  1  kill all in-flight ops
- out_valid  output  1  result valid and write-enable
- result  output  [0:127]  shifted halfwords
- out_tag  output  TAG_W  target register address of result

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: out_valid=0, result=0, out_tag=0, stage-1 valid=0.
- Lane j occupies bits [16j : 16j+15].
- Shift count for lane j: cnt = (0 - rb[16j +: 16]) & 0x1F. This is 5-bit two's-complement negation, range 0..31.
- rothm:
  - cnt < 16: each lane is shifted toward higher bit index by cnt, zero-filled from bit 0.
  - cnt >= 16: lane result is 0.
- rotmah:
  - Same as rothm, but fill bits equal the lane's bit 0 (sign).
  - cnt >= 16: lane is all sign bits.
- Stage 1 (S1) registers:
  - per-lane cnt, ra, op, tag;
  - valid = in_valid && !flush.
- Stage 2 (S2) computes the shift from S1 registers and registers result, out_tag, out_valid.
- Latency: exactly 2 cycles, in_valid at edge N → out_valid at edge N+2. Throughput is one op per cycle.
- Stall:
  - While stall=1, S1 and S2 hold all contents and in_valid is ignored.
  - The caller keeps the op stable until stall deasserts.
  - out_valid remains asserted if it was asserted.
- Flush:
  - S1.valid and out_valid clear at the next edge.
  - A new in_valid arriving in the same cycle as flush is also dropped.
  - Flush overrides stall.
- Reset has priority over flush and stall. Reset mid-operation discards every in-flight op, and no partial result is ever emitted.
- Data regs are don't-care when the matching valid is 0, except after reset, when they are 0.
- Lanes are independent and there is no cross-lane carry.

Optional Feature:
- FX2_ROTHM_IMM_EN defined:
  - Adds ports in_imm_sel (input 1) and imm7 (input 7).
  - When in_imm_sel=1, every lane uses cnt = (0 - imm7) & 0x1F instead of rb. This implements rothmi and rotmahi.
- Macro undefined: the ports are absent and only the register forms (rb counts) are supported.

Decomposition:
- Shared package fx2_pkg holds:
  - HW_W=16, LANES=8, CNT_MASK=5'h1F;
  - FX2 op encodings (OP_ROTHM, OP_ROTMAH);
  - the tag width constant.
- One sub-module, hw_shr16: a combinational 16-bit right shifter with inputs data, cnt[4:0], arith and output out. It is instantiated 8 times in S2.

Test Plan:
- rothm, all lanes ra=16'h8001, rb=16'hFFFF (cnt=1) → after 2 cycles result lanes = 16'h4000, out_valid=1, out_tag matches in_tag.
- rotmah, ra lane=16'h8000, rb=16'hFFF0 (cnt=16) → lane = 16'hFFFF; same lane with rothm → 16'h0000.
- rb=16'h0000 (cnt=0) with ra=16'h1234 → result 16'h1234 for both ops. rb=16'hFFF1 (cnt=15) with rotmah and ra=16'h7FFF → 16'h0000.
- Back-to-back ops A,B,C with stall asserted 3 cycles after B enters → results in order A,B,C with no duplicate or lost out_valid pulse.
- Ops in S1 and S2 when flush pulses, with a new op arriving the same cycle → out_valid=0 for the next 2 cycles.
- rst asserted for 1 cycle mid-stream → out_valid=0, result=0, out_tag=0 next cycle, then normal operation resumes.

Source files
------------

// File: rtl/fx2_pkg.sv
// fx2_pkg: shared constants for the FX2 halfword rotate-and-mask pipes.
//   HW_W      halfword width
//   LANES     halfword lanes per 128-bit operand
//   CNT_MASK  shift-count mask (5-bit count field)
//   OP_*      op encodings for in_op
//   FX2_TAG_W target register address width
// neg_cnt() turns a count halfword into the effective right-shift amount.
package fx2_pkg;

    localparam int       HW_W      = 16;
    localparam int       LANES     = 8;
    localparam int       FX2_TAG_W = 7;
    localparam logic [4:0] CNT_MASK = 5'h1F;

    localparam logic OP_ROTHM  = 1'b0;   // logical right shift
    localparam logic OP_ROTMAH = 1'b1;   // algebraic right shift

    // The ISA encodes right shifts as a negated left count; only the low
    // five bits of the negation survive the mask.
    function automatic logic [4:0] neg_cnt(input logic [15:0] v);
        return 5'((16'd0 - v) & {11'd0, CNT_MASK});
    endfunction

endpackage

// File: rtl/hw_shr16.sv
// hw_shr16: combinational 16-bit right shifter, one per halfword lane.
//   data  [15:0] input   halfword, bit 15 is the sign
//   cnt   [4:0]  input   shift amount 0..31
//   arith        input   1 = fill with sign, 0 = fill with zero
//   out   [15:0] output  shifted halfword
module hw_shr16
    import fx2_pkg::*;
(
    input  logic [15:0] data,
    input  logic [4:0]  cnt,
    input  logic        arith,
    output logic [15:0] out
);

    logic w_fill;

    assign w_fill = arith & data[15];

    always_comb begin
        out = '0;
        if (cnt[4])
            // 16..31 shifts everything out: lane collapses to the fill value
            out = {16{w_fill}};
        else if (arith)
            out = 16'($signed(data) >>> cnt[3:0]);
        else
            out = data >> cnt[3:0];
    end

endmodule

// File: rtl/fx2_rothm_pipe.sv
// fx2_rothm_pipe: FX2 two-stage pipe for rothm / rotmah (and, optionally,
// the immediate forms rothmi / rotmahi) on 8 halfword lanes.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_op      op strobe; 0 = rothm (logical), 1 = rotmah (algebraic)
//   ra, rb [0:127]      source halfwords and per-lane counts (bit 0 = MSB)
//   in_tag              target register address
//   stall, flush        hold both stages / kill all in-flight ops
//   out_valid           result valid and write-enable
//   result [0:127]      shifted halfwords
//   out_tag             target register address of result
// Optional: define FX2_ROTHM_IMM_EN to add in_imm_sel / imm7, which replace
// the per-lane rb counts with one count derived from imm7 for every lane.
// S1 registers operands and per-lane counts; S2 shifts and registers result.
module fx2_rothm_pipe
    import fx2_pkg::*;
#(
    parameter int TAG_W = FX2_TAG_W,
    parameter int LANES = fx2_pkg::LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_op,
    input  logic [0:127]     ra,
    input  logic [0:127]     rb,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             stall,
    input  logic             flush,
`ifdef FX2_ROTHM_IMM_EN
    input  logic             in_imm_sel,
    input  logic [6:0]       imm7,
`endif
    output logic             out_valid,
    output logic [0:127]     result,
    output logic [TAG_W-1:0] out_tag
);

    logic [LANES-1:0][4:0] w_cnt;
    logic [0:127]          w_res;

    logic [LANES-1:0][4:0] r_s1_cnt;
    logic [0:127]          r_s1_ra;
    logic                  r_s1_op;
    logic [TAG_W-1:0]      r_s1_tag;
    logic                  r_s1_vld;

    logic                  r_out_valid;
    logic [0:127]          r_result;
    logic [TAG_W-1:0]      r_out_tag;

`ifdef FX2_ROTHM_IMM_EN
    logic [4:0] w_imm_cnt;
    assign w_imm_cnt = 5'((7'd0 - imm7) & {2'd0, CNT_MASK});
`endif

    genvar j;
    generate
        for (j = 0; j < LANES; j++) begin : g_lane
`ifdef FX2_ROTHM_IMM_EN
            assign w_cnt[j] = in_imm_sel ? w_imm_cnt : neg_cnt(rb[HW_W*j +: HW_W]);
`else
            assign w_cnt[j] = neg_cnt(rb[HW_W*j +: HW_W]);
`endif
            hw_shr16 u_shr (
                .data  (r_s1_ra[HW_W*j +: HW_W]),
                .cnt   (r_s1_cnt[j]),
                .arith (r_s1_op == OP_ROTMAH),
                .out   (w_res[HW_W*j +: HW_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_cnt    <= '0;
            r_s1_ra     <= '0;
            r_s1_op     <= 1'b0;
            r_s1_tag    <= '0;
            r_s1_vld    <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_out_tag   <= '0;
        end else if (flush) begin
            // Kill both stages; the op offered this cycle is dropped too.
            r_s1_vld    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!stall) begin
            r_s1_cnt    <= w_cnt;
            r_s1_ra     <= ra;
            r_s1_op     <= in_op;
            r_s1_tag    <= in_tag;
            r_s1_vld    <= in_valid;
            r_result    <= w_res;
            r_out_tag   <= r_s1_tag;
            r_out_valid <= r_s1_vld;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign out_tag   = r_out_tag;

endmodule
